// File: rtl/motor_dose_ctrl_pkg.sv
// Shared definitions for the dose controller: channel indices, state
// encoding and small one-hot helpers used by the control FSM.
package motor_dose_ctrl_pkg;

    // Channel indices; bit positions in Motores / motor_on / flags
    localparam logic [1:0] CH_R = 2'd2;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // One-hot pump/flag pattern for a channel index
    function automatic logic [2:0] onehot(input logic [1:0] ch);
        logic [2:0] v;
        case (ch)
            CH_R:    v = 3'b100;
            CH_G:    v = 3'b010;
            CH_B:    v = 3'b001;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // True when two or more request bits are set at once
    function automatic logic multi_hot(input logic [2:0] m);
        return (m[0] & m[1]) | (m[0] & m[2]) | (m[1] & m[2]);
    endfunction

    // Channel index of a one-hot request; only meaningful when exactly one bit is set
    function automatic logic [1:0] ch_index(input logic [2:0] m);
        logic [1:0] c;
        if (m[2])
            c = CH_R;
        else if (m[1])
            c = CH_G;
        else
            c = CH_B;
        return c;
    endfunction

endpackage

// File: rtl/motor_dose_ctrl_tick_gen.sv
// Dose-tick prescaler: counts 0..TICK_DIV-1 and pulses tick on the last
// count. Held at zero while clr is high so every run starts a full period.
module tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] pcnt;

    // Free-running modulo-TICK_DIV counter, forced to zero by clr
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pcnt <= '0;
        else if (clr || (pcnt == LAST))
            pcnt <= '0;
        else
            pcnt <= pcnt + CW'(1);
    end

    assign tick = !clr && (pcnt == LAST);

endmodule

// File: rtl/motor_dose_ctrl.sv
// Pump dose controller: on a one-hot request from the sequencing FSM it
// drives the matching pump for dose*TICK_DIV cycles, then raises that
// channel's dose-complete flag until the request is withdrawn.
//
// state | meaning
// IDLE  | waiting for a request, all outputs low
// RUN   | pump motor_on[ch] driven, counting dose ticks down
// DONE  | dose finished, flags[ch] high until request changes
// ERR   | multiple channels requested, wait for Motores == 000
import motor_dose_ctrl_pkg::*;

module motor_dose_ctrl #(
    parameter int TICK_DIV = 50000,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    Motores,
    input  logic [DW-1:0] dose_r,
    input  logic [DW-1:0] dose_g,
    input  logic [DW-1:0] dose_b,
    output logic [2:0]    motor_on,
    output logic [2:0]    flags,
    output logic          busy,
    output logic          error
);

    state_t        state, state_nxt;
    logic [1:0]    ch, ch_nxt;
    logic [DW-1:0] cnt, cnt_nxt;
    logic [1:0]    req_ch;
    logic [DW-1:0] req_dose;
    logic          tick;
    logic          presc_clr;

    // Prescaler only runs in RUN, so each run begins with a fresh full tick period
    assign presc_clr = (state != ST_RUN);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clr  (presc_clr),
        .tick (tick)
    );

    // State, latched channel and remaining-tick register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ch    <= CH_B;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state decode plus outputs decoded from state/ch only
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        cnt_nxt   = cnt;
        motor_on  = 3'b000;
        flags     = 3'b000;
        busy      = 1'b0;
        error     = 1'b0;

        req_ch = ch_index(Motores);
        case (req_ch)
            CH_R:    req_dose = dose_r;
            CH_G:    req_dose = dose_g;
            default: req_dose = dose_b;
        endcase

        if (multi_hot(Motores)) begin
            state_nxt = ST_ERR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Motores != 3'b000) begin
                        ch_nxt    = req_ch;
                        cnt_nxt   = req_dose;
                        // A zero dose completes without ever pulsing the pump
                        state_nxt = (req_dose == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (Motores != onehot(ch)) begin
                        state_nxt = ST_IDLE;
                    end else if (tick) begin
                        cnt_nxt = cnt - DW'(1);
                        if (cnt == DW'(1))
                            state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (Motores != onehot(ch))
                        state_nxt = ST_IDLE;
                end
                ST_ERR: begin
                    if (Motores == 3'b000)
                        state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        case (state)
            ST_RUN: begin
                motor_on = onehot(ch);
                busy     = 1'b1;
            end
            ST_DONE: flags = onehot(ch);
            ST_ERR:  error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_motor_dose_ctrl.sv
// Directed bench for motor_dose_ctrl with TICK_DIV=4. Inputs change and
// outputs are sampled 1 time unit after each rising edge; "cycle k" is the
// interval following the k-th edge after the request is applied.
module tb_motor_dose_ctrl;

    localparam int TICK_DIV = 4;
    localparam int DW       = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    Motores = 3'b000;
    logic [DW-1:0] dose_r = '0;
    logic [DW-1:0] dose_g = '0;
    logic [DW-1:0] dose_b = '0;
    logic [2:0]    motor_on;
    logic [2:0]    flags;
    logic          busy;
    logic          error;

    int checks = 0;
    int errors = 0;

    motor_dose_ctrl #(
        .TICK_DIV(TICK_DIV),
        .DW      (DW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Motores (Motores),
        .dose_r  (dose_r),
        .dose_g  (dose_g),
        .dose_b  (dose_b),
        .motor_on(motor_on),
        .flags   (flags),
        .busy    (busy),
        .error   (error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until flags == m, counting cycles with motor_on == m
    task automatic run_count(input logic [2:0] m, input int exp_on, input string name);
        int  on_cnt = 0;
        bit  got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            if (motor_on === m) on_cnt++;
            if (flags === m) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s flag_timeout flags=%b required=%b", name, flags, m);
        end
        checks++;
        if (on_cnt !== exp_on) begin
            errors++;
            $display("FAIL %s on_time actual=%0d required=%0d", name, on_cnt, exp_on);
        end
        checks++;
        if (motor_on !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s motor_at_done motor_on=%b busy=%b required 000/0", name, motor_on, busy);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({motor_on, flags, busy, error} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs actual=%b required=%b", {motor_on, flags, busy, error}, 8'h00);
        end
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if ({motor_on, flags, busy, error} !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_reset actual=%b required=%b", {motor_on, flags, busy, error}, 8'h00);
        end
    endtask

    task automatic test_single_dose();
        dose_r  = 8'd3;
        Motores = 3'b100;
        for (int c = 1; c <= 12; c++) begin
            step();
            checks++;
            if (motor_on !== 3'b100 || busy !== 1'b1 || flags !== 3'b000) begin
                errors++;
                $display("FAIL single_run cycle %0d motor_on=%b busy=%b flags=%b required 100/1/000",
                         c, motor_on, busy, flags);
            end
            // Dose change mid-run must not alter the on-time
            if (c == 5) dose_r = 8'd9;
        end
        for (int c = 13; c <= 15; c++) begin
            step();
            checks++;
            if (flags !== 3'b100 || motor_on !== 3'b000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL single_done cycle %0d flags=%b motor_on=%b busy=%b required 100/000/0",
                         c, flags, motor_on, busy);
            end
        end
        Motores = 3'b000;
        step();
        checks++;
        if (flags !== 3'b000) begin
            errors++;
            $display("FAIL single_flag_clear flags=%b required=000", flags);
        end
        dose_r = '0;
    endtask

    task automatic test_zero_dose();
        dose_g  = 8'd0;
        Motores = 3'b010;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (flags !== 3'b010 || motor_on !== 3'b000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_dose cycle %0d flags=%b motor_on=%b busy=%b required 010/000/0",
                         c, flags, motor_on, busy);
            end
        end
        Motores = 3'b000;
        step();
        checks++;
        if (flags !== 3'b000) begin
            errors++;
            $display("FAIL zero_flag_clear flags=%b required=000", flags);
        end
    endtask

    task automatic test_full_sequence();
        dose_r  = 8'd2;
        dose_g  = 8'd1;
        dose_b  = 8'd5;
        Motores = 3'b100;
        run_count(3'b100, 8, "seq_r");
        Motores = 3'b010;
        step();
        checks++;
        if (flags !== 3'b000 || motor_on !== 3'b000) begin
            errors++;
            $display("FAIL seq_r_clear flags=%b motor_on=%b required 000/000", flags, motor_on);
        end
        run_count(3'b010, 4, "seq_g");
        Motores = 3'b001;
        step();
        checks++;
        if (flags !== 3'b000 || motor_on !== 3'b000) begin
            errors++;
            $display("FAIL seq_g_clear flags=%b motor_on=%b required 000/000", flags, motor_on);
        end
        run_count(3'b001, 20, "seq_b");
        Motores = 3'b000;
        step();
        checks++;
        if (flags !== 3'b000) begin
            errors++;
            $display("FAIL seq_b_clear flags=%b required=000", flags);
        end
    endtask

    task automatic test_abort();
        dose_b  = 8'd4;
        Motores = 3'b001;
        for (int c = 1; c <= 6; c++) begin
            step();
            checks++;
            if (motor_on !== 3'b001) begin
                errors++;
                $display("FAIL abort_run cycle %0d motor_on=%b required=001", c, motor_on);
            end
        end
        Motores = 3'b000;
        for (int c = 7; c <= 20; c++) begin
            step();
            checks++;
            if (motor_on !== 3'b000 || busy !== 1'b0 || flags !== 3'b000) begin
                errors++;
                $display("FAIL abort_idle cycle %0d motor_on=%b busy=%b flags=%b required 000/0/000",
                         c, motor_on, busy, flags);
            end
        end
    endtask

    task automatic test_illegal();
        Motores = 3'b110;
        step();
        checks++;
        if (error !== 1'b1 || motor_on !== 3'b000 || flags !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_enter error=%b motor_on=%b flags=%b busy=%b required 1/000/000/0",
                     error, motor_on, flags, busy);
        end
        Motores = 3'b100;
        step();
        step();
        checks++;
        if (error !== 1'b1 || motor_on !== 3'b000) begin
            errors++;
            $display("FAIL illegal_hold error=%b motor_on=%b required 1/000", error, motor_on);
        end
        Motores = 3'b000;
        step();
        checks++;
        if (error !== 1'b0 || {motor_on, flags, busy} !== 7'b0) begin
            errors++;
            $display("FAIL illegal_exit error=%b motor_on=%b flags=%b required 0/000/000",
                     error, motor_on, flags);
        end
        dose_r  = 8'd5;
        Motores = 3'b100;
        step();
        checks++;
        if (motor_on !== 3'b100) begin
            errors++;
            $display("FAIL illegal_pre_run motor_on=%b required=100", motor_on);
        end
        Motores = 3'b101;
        step();
        checks++;
        if (error !== 1'b1 || motor_on !== 3'b000) begin
            errors++;
            $display("FAIL illegal_from_run error=%b motor_on=%b required 1/000", error, motor_on);
        end
        Motores = 3'b000;
        step();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL illegal_from_run_exit error=%b required=0", error);
        end
    endtask

    task automatic test_reset_mid_run();
        dose_r  = 8'd5;
        Motores = 3'b100;
        for (int c = 1; c <= 5; c++) step();
        checks++;
        if (motor_on !== 3'b100) begin
            errors++;
            $display("FAIL rst_pre_run motor_on=%b required=100", motor_on);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (motor_on !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async motor_on=%b busy=%b required 000/0", motor_on, busy);
        end
        step();
        step();
        dose_r = 8'd1;
        reset  = 1'b0;
        step();
        checks++;
        if (motor_on !== 3'b100) begin
            errors++;
            $display("FAIL rst_first_edge motor_on=%b required=100", motor_on);
        end
        run_count(3'b100, 3, "rst_redo");
        Motores = 3'b000;
        step();
        checks++;
        if (flags !== 3'b000) begin
            errors++;
            $display("FAIL rst_redo_clear flags=%b required=000", flags);
        end
    endtask

    initial begin
        test_reset();
        test_single_dose();
        test_zero_dose();
        test_full_sequence();
        test_abort();
        test_illegal();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_dose_ctrl.md
MOTOR_DOSE_CTRL -- requirements
Module: motor_dose_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000, means clock cycles per dose tick (1 ms at 50 MHz); legal range is >= 2.
REQ-002 Parameter DW, default 8, means the width of each dose amount in ticks.
REQ-003 Port clk, input, 1 bit, is the single clock; all logic SHALL be rising-edge.
REQ-004 Port reset, input, 1 bit, is the reset: asynchronous, active-high.
REQ-005 Port Motores, input, 3 bits, is the channel request from the sequencing FSM (bit 2 = R, bit 1 = Y/G, bit 0 = B); one-hot or zero is legal.
REQ-006 Ports dose_r, dose_g and dose_b, inputs, DW bits each, are the per-channel dose length in ticks.
REQ-007 Port motor_on, output, 3 bits, is the pump drive, with the same bit mapping as Motores.
REQ-008 Port flags, output, 3 bits, is the per-channel dose-complete level fed back to the FSM.
REQ-009 Port busy, output, 1 bit, SHALL be high while in RUN.
REQ-010 Port error, output, 1 bit, SHALL be high while in ERR.

Function
REQ-011 The block SHALL implement the states IDLE, RUN, DONE and ERR; the active channel index ch SHALL be latched on leaving IDLE.
REQ-012 In IDLE, when Motores is zero, the block SHALL stay in IDLE with all outputs at 0.
REQ-013 In IDLE, when Motores is one-hot for channel c, the block SHALL next cycle latch ch=c, load cnt from dose_c, and clear the prescaler. It SHALL go to RUN when dose_c is nonzero, or to DONE when dose_c is 0, which is a zero dose with no motor pulse.
REQ-014 In any state, when Motores has two or more bits set, the block SHALL go to ERR next cycle.
REQ-015 In RUN, motor_on[ch] SHALL be 1 and all other motor_on bits 0; the latency from Motores assertion to motor_on is 1 cycle.
REQ-016 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and wrap, emitting a tick on the cycle where it equals TICK_DIV-1.
REQ-017 In RUN, each tick SHALL decrement cnt; a tick with cnt==1 SHALL move to DONE next cycle, so motor_on[ch] is high for exactly dose_c*TICK_DIV cycles.
REQ-018 dose_* inputs SHALL be sampled only at IDLE exit; changes during RUN SHALL be ignored.
REQ-019 In RUN, when Motores no longer equals onehot(ch) (abort), the block SHALL go to IDLE next cycle with motor_on cleared and no flag raised.
REQ-020 In DONE, flags[ch] SHALL be 1, other flag bits 0, and motor_on 000; the block SHALL hold while Motores==onehot(ch).
REQ-021 In DONE, when Motores != onehot(ch), the block SHALL go to IDLE next cycle and flags SHALL clear; a new request is accepted from IDLE on the following cycle.
REQ-022 In ERR, motor_on and flags SHALL be 000 and error SHALL be 1; the block SHALL leave to IDLE only when Motores==000.
REQ-023 All outputs SHALL be registered or decoded from state/ch only, with no combinational path from Motores to outputs.

Reset
REQ-024 Asserting reset SHALL immediately force IDLE, ch=0, cnt=0, prescaler=0, and motor_on, flags, busy and error all to 0, including mid-RUN.
REQ-025 After reset deasserts, the block SHALL accept a request on the first clock edge.

Structure
REQ-026 The shared package SHALL hold the channel index constants R=2, G=1, B=0, the state encoding for IDLE/RUN/DONE/ERR, and the onehot(ch) helper.
REQ-027 The prescaler SHALL be a separate sub-module tick_gen, with ports clk, reset, clr and tick, parameterised by TICK_DIV.
REQ-028 The control logic SHALL be a two-process FSM (state register plus next-state/output decode).

Verification (TICK_DIV=4)
REQ-029 Single dose: dose_r=3, Motores=100 at cycle 0 -> motor_on=100 on cycles 1-12, busy=1 on cycles 1-12, flags=100 from cycle 13 until Motores drops.
REQ-030 Zero dose: dose_g=0, Motores=010 -> motor_on stays 000, flags=010 from cycle 1.
REQ-031 Full sequence: the FSM model steps Motores 100->010->001 on each flag with doses 2/1/5 -> motor on-times of 8, 4 and 20 cycles, each flag clearing 1 cycle after Motores changes.
REQ-032 Abort: Motores drops to 000 on cycle 6 of a dose_b=4 run -> motor_on=000 and IDLE from cycle 7, flags never set.
REQ-033 Illegal request: Motores=110 -> error=1 and motor_on=000 next cycle; error stays 1 until Motores=000, then IDLE.
REQ-034 Reset mid-RUN: reset asserted asynchronously between clock edges at cycle 5 -> motor_on=000 immediately with no clock edge; after release, a new dose_r=1 request completes in 4 cycles.
